// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder path.
// Holds the homing FSM state encoding and the default encoder and homing
// constants used by quad_position_ctrl and the other encoder blocks.
package qenc_pkg;

  // The encoding is visible on the controller's state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_HOMED = 2'd2,
    ST_FAULT = 2'd3
  } qstate_t;

  localparam int DEFAULT_PULSES_PER_REV = 360;
  localparam int DEFAULT_HOME_TIMEOUT   = 50_000_000;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for an already synchronised level.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset; clears the previous-value register
//   in    - level to watch
//   rise  - high in the same cycle 'in' is first seen high after being low
// The output is named 'rise' because 'edge' is a reserved word.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/quad_position_ctrl.sv
// Quadrature position counter with index-based homing.
// Counts encoder pulses into a signed position, homes on the first index
// edge after a homing request, then tracks revolutions and checks that each
// index period contains PULSES_PER_REV pulses.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   count_pulse  - one-cycle count strobe; direction: 1 = up, 0 = down
//   index        - synchronised index level
//   home_start   - one-cycle homing request
//   home_abort   - one-cycle abort of SEEK/HOMED back to IDLE
//   clear_fault  - one-cycle clear of fault and rev_error
//   position     - signed position, wraps modulo 2^POS_WIDTH
//   state        - FSM state (IDLE=0, SEEK=1, HOMED=2, FAULT=3)
//   homed        - high only in HOMED
//   fault        - sticky homing timeout
//   rev_error    - sticky index-period mismatch
//   revolutions  - signed index-edge count since homing
// All outputs come straight from registers.
module quad_position_ctrl #(
  parameter int POS_WIDTH      = 32,
  parameter int PULSES_PER_REV = qenc_pkg::DEFAULT_PULSES_PER_REV,
  parameter int HOME_TIMEOUT   = qenc_pkg::DEFAULT_HOME_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        count_pulse,
  input  logic                        direction,
  input  logic                        index,
  input  logic                        home_start,
  input  logic                        home_abort,
  input  logic                        clear_fault,
  output logic signed [POS_WIDTH-1:0] position,
  output logic [1:0]                  state,
  output logic                        homed,
  output logic                        fault,
  output logic                        rev_error,
  output logic signed [15:0]          revolutions
);

  import qenc_pkg::*;

  localparam int TO_W  = $clog2(HOME_TIMEOUT) + 1;
  localparam int PER_W = $clog2(PULSES_PER_REV) + 2;

  localparam logic [TO_W-1:0]         TO_LAST   = TO_W'(HOME_TIMEOUT - 1);
  localparam logic [TO_W-1:0]         TO_ONE    = TO_W'(1);
  localparam logic signed [PER_W-1:0] PER_NOM   = PER_W'(PULSES_PER_REV);
  localparam logic [PER_W-1:0]        PER_UP    = PER_W'(1);
  localparam logic [PER_W-1:0]        PER_DOWN  = '1;
  localparam logic [POS_WIDTH-1:0]    POS_UP    = POS_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0]    POS_DOWN  = '1;
  localparam logic [15:0]             REV_UP    = 16'd1;
  localparam logic [15:0]             REV_DOWN  = 16'hFFFF;

  qstate_t                  cur_state;
  logic [TO_W-1:0]          timeout_cnt;
  logic signed [PER_W-1:0]  period_cnt;
  logic signed [PER_W-1:0]  period_next;
  logic                     last_dir;
  logic                     pulse_dir;
  logic                     index_rise;
  logic                     homing_edge;
  logic                     pulse_taken;

  edge_detect_rise u_index_edge (
    .clk   (clk),
    .reset (reset),
    .in    (index),
    .rise  (index_rise)
  );

  // The index edge that completes homing zeroes position; a pulse in that
  // same cycle is dropped rather than applied on top of the zero.
  assign homing_edge = (cur_state == ST_SEEK) && index_rise && !home_abort;
  assign pulse_taken = count_pulse && !homing_edge;

  // A pulse coincident with an index edge belongs to the period that is
  // ending, so both the period check and the revolution direction see it.
  assign period_next = count_pulse ? period_cnt + (direction ? PER_UP : PER_DOWN)
                                   : period_cnt;
  assign pulse_dir   = count_pulse ? direction : last_dir;

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= ST_IDLE;
      position    <= '0;
      revolutions <= '0;
      homed       <= 1'b0;
      fault       <= 1'b0;
      rev_error   <= 1'b0;
      timeout_cnt <= '0;
      period_cnt  <= '0;
      last_dir    <= 1'b1;
    end else begin
      if (pulse_taken) begin
        position <= position + (direction ? POS_UP : POS_DOWN);
        last_dir <= direction;
      end

      case (cur_state)
        ST_IDLE: begin
          if (home_start) begin
            cur_state   <= ST_SEEK;
            timeout_cnt <= '0;
          end
        end

        ST_SEEK: begin
          if (home_abort) begin
            cur_state <= ST_IDLE;
          end else if (index_rise) begin
            // Checked before the timeout so an edge on the last cycle still homes.
            cur_state   <= ST_HOMED;
            homed       <= 1'b1;
            position    <= '0;
            revolutions <= '0;
            period_cnt  <= '0;
          end else if (timeout_cnt == TO_LAST) begin
            cur_state <= ST_FAULT;
            fault     <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + TO_ONE;
          end
        end

        ST_HOMED: begin
          if (home_abort) begin
            cur_state <= ST_IDLE;
            homed     <= 1'b0;
          end else if (home_start) begin
            cur_state   <= ST_SEEK;
            homed       <= 1'b0;
            timeout_cnt <= '0;
          end else if (index_rise) begin
            revolutions <= revolutions + (pulse_dir ? REV_UP : REV_DOWN);
            period_cnt  <= '0;
            if ((period_next != PER_NOM) && (period_next != -PER_NOM))
              rev_error <= 1'b1;
          end else begin
            period_cnt <= period_next;
          end
        end

        ST_FAULT: begin
          if (clear_fault) begin
            cur_state <= ST_IDLE;
            fault     <= 1'b0;
          end
        end
      endcase

      // Last assignment wins: a clear beats a mismatch flagged in the same cycle.
      if (clear_fault) rev_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_position_ctrl.sv
// Self-checking bench for quad_position_ctrl.
// A 32-bit instance with HOME_TIMEOUT=16 carries the main checks; an 8-bit
// instance sharing the same inputs exposes position wrap-around cheaply.
// Phases: reset values, a directed vector table, hand-written homing /
// revolution / timeout / wrap / reset sequences, then randomized traffic
// compared against a behavioural model.
module tb_quad_position_ctrl;

  localparam int HT    = 16;
  localparam int PPR   = 360;
  localparam int PER_W = $clog2(PPR) + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic count_pulse = 1'b0;
  logic direction = 1'b1;
  logic index = 1'b0;
  logic home_start = 1'b0;
  logic home_abort = 1'b0;
  logic clear_fault = 1'b0;

  logic signed [31:0] position;
  logic [1:0]         state;
  logic               homed, fault, rev_error;
  logic signed [15:0] revolutions;

  logic signed [7:0]  position_w;
  logic [1:0]         state_w;
  logic               homed_w, fault_w, rev_error_w;
  logic signed [15:0] revolutions_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  quad_position_ctrl #(.POS_WIDTH(32), .PULSES_PER_REV(PPR), .HOME_TIMEOUT(HT)) dut (
    .clk(clk), .reset(reset), .count_pulse(count_pulse), .direction(direction),
    .index(index), .home_start(home_start), .home_abort(home_abort),
    .clear_fault(clear_fault), .position(position), .state(state),
    .homed(homed), .fault(fault), .rev_error(rev_error), .revolutions(revolutions)
  );

  quad_position_ctrl #(.POS_WIDTH(8), .PULSES_PER_REV(PPR), .HOME_TIMEOUT(HT)) dut_w (
    .clk(clk), .reset(reset), .count_pulse(count_pulse), .direction(direction),
    .index(index), .home_start(home_start), .home_abort(home_abort),
    .clear_fault(clear_fault), .position(position_w), .state(state_w),
    .homed(homed_w), .fault(fault_w), .rev_error(rev_error_w),
    .revolutions(revolutions_w)
  );

  // ---------------- behavioural reference model ----------------
  int      m_state;     // 0 idle, 1 seek, 2 homed, 3 fault
  int      m_pos;       // int arithmetic wraps modulo 2^32
  shortint m_revs;      // wraps modulo 2^16
  bit      m_homed, m_fault, m_err, m_last_dir, m_prev_idx;
  int      m_seek_cycles;
  int      m_period;

  function automatic int wrap_period(input int v);
    int span = 1 << PER_W;
    int r = ((v % span) + span) % span;
    if (r >= span / 2) r -= span;
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_revs = 0; m_homed = 0; m_fault = 0; m_err = 0;
    m_last_dir = 1; m_prev_idx = 0; m_seek_cycles = 0; m_period = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit rise;
    int delta;
    bit dir_now;
    int p_end;
    if (reset) begin
      model_reset();
      return;
    end
    rise = index && !m_prev_idx;
    m_prev_idx = index;
    delta = count_pulse ? (direction ? 1 : -1) : 0;
    dir_now = count_pulse ? direction : m_last_dir;
    if (m_state == 1 && rise && !home_abort) begin
      // homing edge: position zeroed, coincident pulse dropped
      m_state = 2; m_homed = 1; m_pos = 0; m_revs = 0; m_period = 0;
    end else begin
      m_pos += delta;
      if (count_pulse) m_last_dir = direction;
      case (m_state)
        0: if (home_start) begin m_state = 1; m_seek_cycles = 0; end
        1: begin
          if (home_abort) m_state = 0;
          else if (m_seek_cycles == HT - 1) begin m_state = 3; m_fault = 1; end
          else m_seek_cycles++;
        end
        2: begin
          if (home_abort) begin m_state = 0; m_homed = 0; end
          else if (home_start) begin m_state = 1; m_homed = 0; m_seek_cycles = 0; end
          else if (rise) begin
            p_end = wrap_period(m_period + delta);
            m_revs += dir_now ? 16'sd1 : -16'sd1;
            if (p_end != PPR && p_end != -PPR) m_err = 1;
            m_period = 0;
          end else begin
            m_period = wrap_period(m_period + delta);
          end
        end
        default: if (clear_fault) begin m_state = 0; m_fault = 0; end
      endcase
    end
    if (clear_fault) m_err = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    count_pulse = 0; home_start = 0; home_abort = 0; clear_fault = 0; reset = 0;
  endtask

  task automatic do_reset();
    clear_strobes();
    index = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic pulses(input int n, input bit dir);
    for (int k = 0; k < n; k++) begin
      count_pulse = 1; direction = dir;
      tick();
    end
    count_pulse = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit p, d, idx, st, ab, cf;
    int e_state;
    int e_pos;
    bit e_homed;
    bit e_err;
    int e_revs;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int fault_at;

    // p d idx st ab cf | state pos homed err revs
    vecs[0]  = '{1,1,0,0,0,0, 0,  1, 0,0,  0};
    vecs[1]  = '{1,1,0,0,0,0, 0,  2, 0,0,  0};
    vecs[2]  = '{1,0,0,0,0,0, 0,  1, 0,0,  0};
    vecs[3]  = '{0,0,0,1,0,0, 1,  1, 0,0,  0};
    vecs[4]  = '{1,1,0,0,0,0, 1,  2, 0,0,  0};
    vecs[5]  = '{1,1,1,0,0,0, 2,  0, 1,0,  0};  // index edge with pulse: pulse dropped
    vecs[6]  = '{1,0,1,0,0,0, 2, -1, 1,0,  0};  // index held high: no edge
    vecs[7]  = '{0,0,0,0,0,0, 2, -1, 1,0,  0};
    vecs[8]  = '{0,0,1,0,0,0, 2, -1, 1,1, -1};  // period -1: wrong length, backwards rev
    vecs[9]  = '{0,0,0,0,1,1, 0, -1, 0,0, -1};  // abort + clear together
    vecs[10] = '{0,0,0,0,1,0, 0, -1, 0,0, -1};  // abort ignored in IDLE
    vecs[11] = '{0,0,0,0,0,1, 0, -1, 0,0, -1};
    vecs[12] = '{0,0,0,1,0,0, 1, -1, 0,0, -1};
    vecs[13] = '{0,0,0,0,1,0, 0, -1, 0,0, -1};  // abort from SEEK, position kept
    vecs[14] = '{0,0,1,0,0,0, 0, -1, 0,0, -1};  // index edge ignored in IDLE
    vecs[15] = '{1,1,0,0,0,0, 0,  0, 0,0, -1};

    // Reset values
    do_reset();
    check("reset_state", state, 0);
    check("reset_position", position, 0);
    check("reset_homed", homed, 0);
    check("reset_fault", fault, 0);
    check("reset_rev_error", rev_error, 0);
    check("reset_revolutions", revolutions, 0);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      count_pulse = vecs[i].p; direction = vecs[i].d; index = vecs[i].idx;
      home_start = vecs[i].st; home_abort = vecs[i].ab; clear_fault = vecs[i].cf;
      tick();
      check($sformatf("vec%0d_state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d_position", i), position, vecs[i].e_pos);
      check($sformatf("vec%0d_homed", i), homed, vecs[i].e_homed);
      check($sformatf("vec%0d_rev_error", i), rev_error, vecs[i].e_err);
      check($sformatf("vec%0d_revolutions", i), revolutions, vecs[i].e_revs);
    end
    clear_strobes(); index = 0;

    // Homing: 5 pulses in IDLE, home_start, index edge 10 cycles later
    do_reset();
    pulses(5, 1);
    check("home_pos_before", position, 5);
    home_start = 1; tick(); home_start = 0;
    check("home_seek_state", state, 1);
    for (int k = 0; k < 9; k++) tick();
    check("home_still_seek", state, 1);
    index = 1; tick();
    check("home_state", state, 2);
    check("home_position", position, 0);
    check("home_homed", homed, 1);

    // Revolutions: exact period, then a short one
    index = 0; tick();
    pulses(PPR, 1);
    index = 1; tick();
    check("rev1_revolutions", revolutions, 1);
    check("rev1_rev_error", rev_error, 0);
    check("rev1_position", position, PPR);
    index = 0; tick();
    pulses(PPR - 1, 1);
    index = 1; tick();
    check("rev2_revolutions", revolutions, 2);
    check("rev2_rev_error", rev_error, 1);
    index = 0;
    home_start = 1; tick(); home_start = 0;
    check("rehome_state", state, 1);
    check("rehome_homed", homed, 0);

    // Timeout: FAULT exactly HT cycles after entering SEEK
    do_reset();
    home_start = 1; tick(); home_start = 0;
    fault_at = -1;
    for (int k = 1; k <= 40 && fault_at < 0; k++) begin
      tick();
      if (state == 2'd3) fault_at = k;
    end
    check("timeout_cycles", fault_at, HT);
    check("timeout_fault", fault, 1);
    home_start = 1; tick(); home_start = 0;
    check("fault_ignores_start", state, 3);
    clear_fault = 1; tick(); clear_fault = 0;
    check("clear_fault_state", state, 0);
    check("clear_fault_fault", fault, 0);

    // Index edge on the timeout cycle wins
    do_reset();
    home_start = 1; tick(); home_start = 0;
    for (int k = 0; k < HT - 1; k++) tick();
    check("edge_timeout_pre", state, 1);
    index = 1; tick(); index = 0;
    check("edge_timeout_state", state, 2);
    check("edge_timeout_fault", fault, 0);

    // Wrap-around on the 8-bit instance
    do_reset();
    pulses(127, 1);
    check("wrap_max", position_w, 127);
    pulses(1, 1);
    check("wrap_up", position_w, -128);
    check("wrap_wide", position, 128);
    pulses(1, 0);
    check("wrap_down", position_w, 127);

    // Reset mid-SEEK
    do_reset();
    pulses(42, 1);
    home_start = 1; tick(); home_start = 0;
    check("midseek_state", state, 1);
    check("midseek_position", position, 42);
    reset = 1; tick(); reset = 0;
    check("rst_state", state, 0);
    check("rst_position", position, 0);
    check("rst_flags", {homed, fault, rev_error}, 0);
    check("rst_revolutions", revolutions, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(399) == 0);
      count_pulse = $urandom_range(1);
      direction   = $urandom_range(1);
      if ($urandom_range(15) == 0) index = ~index;
      home_start  = ($urandom_range(19) == 0);
      home_abort  = ($urandom_range(79) == 0);
      clear_fault = ($urandom_range(39) == 0);
      tick();
      check("rnd_state", state, m_state);
      check("rnd_position", position, m_pos);
      check("rnd_homed", homed, m_homed);
      check("rnd_fault", fault, m_fault);
      check("rnd_rev_error", rev_error, m_err);
      check("rnd_revolutions", revolutions, m_revs);
      check("rnd_position_w", position_w, byte'(m_pos));
    end
    clear_strobes();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
